// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stalls, branch
// flushes, multi-cycle mult/div stall sequencing and saturating event counters.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | normal flow; load-use detection active; md_start issues mult/div
// MD_BUSY | mult/div in progress; front end held, bubbles into MEM
// MD_DONE | final mult/div cycle; EX instruction advances
module hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic          id_uses_rt,
    input  logic [4:0]    ex_rt,
    input  logic          ex_memread,
    input  logic          md_start,
    input  logic          branch_taken,
    output logic          stall_pc,
    output logic          stall_ifid,
    output logic          stall_idex,
    output logic          zero_ifid,
    output logic          zero_idex,
    output logic          zero_exmem,
    output logic          md_busy,
    output logic          md_done,
    output logic [CW-1:0] stall_count,
    output logic [CW-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    // Remaining MD_BUSY cycles minus one, loaded in the issue cycle.
    localparam logic [4:0] MD_LOAD = (MD_LAT > 2) ? 5'(MD_LAT - 3) : 5'd0;

    state_t     state, state_nxt;
    logic [4:0] md_cnt, md_cnt_nxt;
    logic       load_use;

    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            md_cnt <= 5'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        stall_idex = 1'b0;
        zero_ifid  = 1'b0;
        zero_idex  = 1'b0;
        zero_exmem = 1'b0;
        md_busy    = 1'b0;
        md_done    = 1'b0;

        if (reset) begin
            zero_ifid  = 1'b1;
            zero_idex  = 1'b1;
            zero_exmem = 1'b1;
        end else if (branch_taken) begin
            // The in-flight mult/div is younger than the branch, so it is cancelled.
            zero_ifid  = 1'b1;
            zero_idex  = 1'b1;
            zero_exmem = 1'b1;
            state_nxt  = RUN;
            md_cnt_nxt = 5'd0;
        end else begin
            case (state)
                RUN: begin
                    if (md_start) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        stall_idex = 1'b1;
                        zero_exmem = 1'b1;
                        md_busy    = 1'b1;
                        md_cnt_nxt = MD_LOAD;
                        state_nxt  = (MD_LAT > 2) ? MD_BUSY : MD_DONE;
                    end else if (load_use) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        zero_idex  = 1'b1;
                    end
                end
                MD_BUSY: begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    stall_idex = 1'b1;
                    zero_exmem = 1'b1;
                    md_busy    = 1'b1;
                    if (md_cnt == 5'd0) begin
                        state_nxt = MD_DONE;
                    end else begin
                        md_cnt_nxt = md_cnt - 5'd1;
                    end
                end
                MD_DONE: begin
                    md_done   = 1'b1;
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt  = RUN;
                    md_cnt_nxt = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_pc && (stall_count != {CW{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
            if (branch_taken && (flush_count != {CW{1'b1}})) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule
